acionamento_motor_janela: RTL and testbench

Motor driver stage downstream of the window open/close decision logic. Consumes the ABRIR/FECHAR requests and the A (fully open) and F (fully closed) limit switches, and drives the two motor-direction outputs. Guarantees the two directions are never driven together, inserts a dead-time before every start and reversal, stops at the limits, and latches a fault on travel timeout or contradictory limit switches.

---
 rtl/acionamento_motor_janela_pkg.sv | 17 +
 rtl/acionamento_motor_janela_contador_ciclos.sv | 33 +++
 rtl/acionamento_motor_janela.sv | 132 +++++++++++++
 tb/tb_acionamento_motor_janela.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acionamento_motor_janela_pkg.sv
// Shared encodings for the window motor driver: FSM states and pending travel direction.
package pkg_janela;

  typedef enum logic [2:0] {
    ST_PARADO   = 3'd0,
    ST_ESPERA   = 3'd1,
    ST_ABRINDO  = 3'd2,
    ST_FECHANDO = 3'd3,
    ST_FALHA    = 3'd4
  } estado_t;

  typedef enum logic {
    DIR_ABRE  = 1'b0,
    DIR_FECHA = 1'b1
  } dir_t;

endpackage

// File: rtl/acionamento_motor_janela_contador_ciclos.sv
// Cycle counter shared by the dead-time wait and the travel timeout; clear beats increment.
module contador_ciclos #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/acionamento_motor_janela.sv
// Window motor driver: Moore FSM with dead-time before every start/reversal,
// limit-switch stop, travel timeout and contradictory-sensor fault latch.
module acionamento_motor_janela
  import pkg_janela::*;
#(
  parameter int unsigned DEADTIME = 4,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned CW       = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic ABRIR,
  input  logic FECHAR,
  input  logic A,
  input  logic F,
  input  logic LIMPA_FALHA,
  output logic MOTOR_ABRE,
  output logic MOTOR_FECHA,
  output logic OCUPADO,
  output logic FALHA
);

  localparam logic [CW-1:0] DT_ULTIMO = CW'(DEADTIME - 1);
  localparam logic [CW-1:0] TO_ULTIMO = CW'(TIMEOUT - 1);

  estado_t       state_q, state_d;
  dir_t          dir_q, dir_d;
  dir_t          dir_pedida;
  logic          reinicia;
  logic          cnt_clr, cnt_inc;
  logic [CW-1:0] cnt;

  contador_ciclos #(.CW(CW)) u_contador (
    .clk   (CLK),
    .rst   (RST),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt)
  );

  // Close wins when both requests are present (rain-safe direction).
  assign dir_pedida = FECHAR ? DIR_FECHA : DIR_ABRE;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_inc  = 1'b0;
    reinicia = 1'b0;
    if (A && F && state_q != ST_FALHA) begin
      state_d = ST_FALHA;
    end else begin
      case (state_q)
        ST_PARADO: begin
          if (FECHAR && !F) begin
            state_d = ST_ESPERA;
            dir_d   = DIR_FECHA;
          end else if (ABRIR && !A) begin
            state_d = ST_ESPERA;
            dir_d   = DIR_ABRE;
          end
        end
        ST_ESPERA: begin
          if (!ABRIR && !FECHAR) begin
            state_d = ST_PARADO;
          end else if ((dir_pedida == DIR_FECHA) ? F : A) begin
            state_d = ST_PARADO;
          end else if (dir_pedida != dir_q) begin
            dir_d    = dir_pedida;
            reinicia = 1'b1;
          end else if (cnt == DT_ULTIMO) begin
            state_d = (dir_q == DIR_ABRE) ? ST_ABRINDO : ST_FECHANDO;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_ABRINDO: begin
          if (A) begin
            state_d = ST_PARADO;
          end else if (FECHAR) begin
            state_d = ST_ESPERA;
            dir_d   = DIR_FECHA;
          end else if (!ABRIR) begin
            state_d = ST_PARADO;
          end else if (cnt == TO_ULTIMO) begin
            state_d = ST_FALHA;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_FECHANDO: begin
          if (F) begin
            state_d = ST_PARADO;
          end else if (ABRIR && !FECHAR) begin
            state_d = ST_ESPERA;
            dir_d   = DIR_ABRE;
          end else if (!FECHAR) begin
            state_d = ST_PARADO;
          end else if (cnt == TO_ULTIMO) begin
            state_d = ST_FALHA;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_FALHA: begin
          if (LIMPA_FALHA && !(A && F)) begin
            state_d = ST_PARADO;
          end
        end
        default: state_d = ST_PARADO;
      endcase
    end
    // Every state entry, and a direction flip inside ESPERA, restarts the count.
    cnt_clr = reinicia || (state_d != state_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_PARADO;
      dir_q   <= DIR_ABRE;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  assign MOTOR_ABRE  = (state_q == ST_ABRINDO);
  assign MOTOR_FECHA = (state_q == ST_FECHANDO);
  assign OCUPADO     = (state_q == ST_ESPERA) || (state_q == ST_ABRINDO) ||
                       (state_q == ST_FECHANDO);
  assign FALHA       = (state_q == ST_FALHA);

endmodule

// File: tb/tb_acionamento_motor_janela.sv
// Directed scenarios followed by randomized traffic, checked cycle-by-cycle against a rule-level model.
module tb_acionamento_motor_janela;

  localparam int unsigned DT = 4;
  localparam int unsigned TO = 10;
  localparam int unsigned CW = 8;

  localparam int IDLE  = 0;
  localparam int WAIT  = 1;
  localparam int RUN   = 2;
  localparam int FAULT = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ABRIR = 1'b0, FECHAR = 1'b0, A = 1'b0, F = 1'b0, LIMPA_FALHA = 1'b0;
  logic MOTOR_ABRE, MOTOR_FECHA, OCUPADO, FALHA;

  int compared   = 0;
  int mismatched = 0;

  // Model: mode, direction as +1 (open) / -1 (close), cycles spent in the current phase.
  int m_mode = IDLE;
  int m_dir  = 1;
  int m_n    = 0;

  // Invariant tracking: last direction energised and length of the current all-off run.
  int  last_dir = 0;
  int  low_run  = 0;
  logic prev_abre  = 1'b0;
  logic prev_fecha = 1'b0;

  acionamento_motor_janela #(.DEADTIME(DT), .TIMEOUT(TO), .CW(CW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ABRIR       (ABRIR),
    .FECHAR      (FECHAR),
    .A           (A),
    .F           (F),
    .LIMPA_FALHA (LIMPA_FALHA),
    .MOTOR_ABRE  (MOTOR_ABRE),
    .MOTOR_FECHA (MOTOR_FECHA),
    .OCUPADO     (OCUPADO),
    .FALHA       (FALHA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = IDLE;
    m_dir  = 1;
    m_n    = 0;
  endtask

  task automatic model_step();
    int want, limit, reverse, keep;
    if (m_mode != FAULT && A && F) begin
      m_mode = FAULT;
      m_n    = 0;
    end else begin
      case (m_mode)
        IDLE: begin
          if (FECHAR && !F) begin
            m_mode = WAIT; m_dir = -1; m_n = 0;
          end else if (ABRIR && !A) begin
            m_mode = WAIT; m_dir = 1; m_n = 0;
          end
        end
        WAIT: begin
          want = FECHAR ? -1 : (ABRIR ? 1 : 0);
          if (want == 0 || (want == -1 && F) || (want == 1 && A)) begin
            m_mode = IDLE; m_n = 0;
          end else if (want != m_dir) begin
            m_dir = want; m_n = 0;
          end else if (m_n + 1 == int'(DT)) begin
            m_mode = RUN; m_n = 0;
          end else begin
            m_n++;
          end
        end
        RUN: begin
          limit   = (m_dir > 0) ? int'(A) : int'(F);
          reverse = (m_dir > 0) ? int'(FECHAR) : int'(ABRIR && !FECHAR);
          keep    = (m_dir > 0) ? int'(ABRIR) : int'(FECHAR);
          if (limit != 0) begin
            m_mode = IDLE; m_n = 0;
          end else if (reverse != 0) begin
            m_mode = WAIT; m_dir = -m_dir; m_n = 0;
          end else if (keep == 0) begin
            m_mode = IDLE; m_n = 0;
          end else if (m_n + 1 == int'(TO)) begin
            m_mode = FAULT; m_n = 0;
          end else begin
            m_n++;
          end
        end
        default: begin
          if (LIMPA_FALHA && !(A && F)) begin
            m_mode = IDLE; m_n = 0;
          end
        end
      endcase
    end
  endtask

  task automatic check_outputs();
    chk("motor_abre",  MOTOR_ABRE,  logic'(m_mode == RUN && m_dir > 0));
    chk("motor_fecha", MOTOR_FECHA, logic'(m_mode == RUN && m_dir < 0));
    chk("ocupado",     OCUPADO,     logic'(m_mode == WAIT || m_mode == RUN));
    chk("falha",       FALHA,       logic'(m_mode == FAULT));
    chk("never_both_high", logic'(MOTOR_ABRE && MOTOR_FECHA), 1'b0);
    if (MOTOR_ABRE && !prev_abre && last_dir == -1)
      chk("deadtime_before_open", logic'(low_run >= int'(DT)), 1'b1);
    if (MOTOR_FECHA && !prev_fecha && last_dir == 1)
      chk("deadtime_before_close", logic'(low_run >= int'(DT)), 1'b1);
    if (MOTOR_ABRE) begin
      last_dir = 1; low_run = 0;
    end else if (MOTOR_FECHA) begin
      last_dir = -1; low_run = 0;
    end else begin
      low_run++;
    end
    prev_abre  = MOTOR_ABRE;
    prev_fecha = MOTOR_FECHA;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) model_reset();
    else     model_step();
    #1;
    check_outputs();
  endtask

  task automatic wait_motor(input string tag, input logic abre, output int edges);
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if ((abre && MOTOR_ABRE) || (!abre && MOTOR_FECHA)) begin
        edges = i;
        break;
      end
    end
    if (edges < 0) chk_int(tag, edges, 0);
  endtask

  initial begin
    int e, n, h;

    // Reset state
    tick();
    tick();
    chk("rst_motor_abre", MOTOR_ABRE, 1'b0);
    chk("rst_motor_fecha", MOTOR_FECHA, 1'b0);
    chk("rst_ocupado", OCUPADO, 1'b0);
    chk("rst_falha", FALHA, 1'b0);
    RST = 1'b0;

    // Start open: request sampled at edge 1, motor first high after edge DT+1
    ABRIR = 1'b1;
    e = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (e < 0 && MOTOR_ABRE) e = i;
    end
    chk_int("start_latency", e, int'(DT) + 1);
    A = 1'b1;
    tick();
    chk("open_limit_motor", MOTOR_ABRE, 1'b0);
    chk("open_limit_ocupado", OCUPADO, 1'b0);
    A = 1'b0; ABRIR = 1'b0;
    tick();

    // Reversal from opening to closing goes through the dead-time
    ABRIR = 1'b1;
    wait_motor("reversal_open_timeout", 1'b1, e);
    ABRIR = 1'b0; FECHAR = 1'b1;
    tick();
    chk("reversal_abre_drop", MOTOR_ABRE, 1'b0);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (MOTOR_FECHA) break;
      n++;
    end
    chk_int("reversal_gap", n, int'(DT));
    FECHAR = 1'b0;
    tick();

    // Both requests: close wins; dropping FECHAR in ESPERA flips to open
    ABRIR = 1'b1; FECHAR = 1'b1;
    tick();
    chk("prio_ocupado", OCUPADO, 1'b1);
    tick();
    FECHAR = 1'b0;
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (MOTOR_ABRE) break;
    end
    chk_int("abort_flip_latency", n, int'(DT));
    ABRIR = 1'b0;
    tick();

    // Timeout: direction held exactly TO cycles, then sticky fault
    FECHAR = 1'b1;
    wait_motor("timeout_start", 1'b0, e);
    h = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!MOTOR_FECHA) break;
      h++;
    end
    chk_int("timeout_len", h, int'(TO));
    chk("timeout_falha", FALHA, 1'b1);
    for (int i = 0; i < 6; i++) begin
      FECHAR = ~FECHAR;
      ABRIR  = FECHAR;
      tick();
      chk("falha_sticky", FALHA, 1'b1);
    end
    FECHAR = 1'b0; ABRIR = 1'b0;
    LIMPA_FALHA = 1'b1;
    tick();
    LIMPA_FALHA = 1'b0;
    chk("falha_cleared", FALHA, 1'b0);
    tick();

    // Contradictory limit switches during closing
    FECHAR = 1'b1;
    wait_motor("sensor_start", 1'b0, e);
    A = 1'b1; F = 1'b1;
    tick();
    chk("sensor_falha", FALHA, 1'b1);
    chk("sensor_motor_off", MOTOR_FECHA, 1'b0);
    LIMPA_FALHA = 1'b1;
    tick();
    chk("sensor_clear_blocked", FALHA, 1'b1);
    A = 1'b0; F = 1'b0; FECHAR = 1'b0;
    tick();
    LIMPA_FALHA = 1'b0;
    chk("sensor_cleared", FALHA, 1'b0);
    tick();

    // Asynchronous reset between edges while opening
    ABRIR = 1'b1;
    wait_motor("async_start", 1'b1, e);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_abre", MOTOR_ABRE, 1'b0);
    chk("async_rst_ocupado", OCUPADO, 1'b0);
    tick();
    RST = 1'b0; ABRIR = 1'b0;
    tick();
    chk("post_rst_ocupado", OCUPADO, 1'b0);

    // Randomized traffic with held input patterns
    for (int blk = 0; blk < 120; blk++) begin
      ABRIR       = ($urandom_range(0, 99) < 45);
      FECHAR      = ($urandom_range(0, 99) < 30);
      A           = ($urandom_range(0, 99) < 8);
      F           = ($urandom_range(0, 99) < 8);
      LIMPA_FALHA = ($urandom_range(0, 99) < 15);
      repeat ($urandom_range(1, 6)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
